mem_responder: RTL and testbench

- Memory-side responder for the memory interface used by the memory test benches.
- Stores 2**ADDR_WIDTH words of DATA_WIDTH bits and services single-word read/write requests through a ready/ack handshake.
- Inserts a programmable number of wait states per access.
- Sweeps all words to zero after every reset, so benches can rely on a cleared array without issuing writes.

---
 rtl/mem_responder.sv | 192 +++++++++++++++++++
 tb/tb_mem_responder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder holding 2**ADDR_WIDTH words of
// DATA_WIDTH bits. It services single-word reads and writes and inserts
// WAIT_STATES extra cycles between accepting a request and acknowledging it.
// After every reset it sweeps the whole array to zero before it accepts
// any request.
//
// Ports:
//   clk         - single clock; all logic updates on the rising edge
//   rst         - synchronous, active-high reset
//   read        - read request (sampled only while ready=1)
//   write       - write request (sampled only while ready=1)
//   addr        - request address
//   data_in     - write data
//   data_out    - read data; valid while ack=1 after a read, then held
//   ready       - responder accepts a request on this cycle's edge
//   ack         - one-cycle pulse: the accepted request has completed
//   err         - one-cycle pulse: read and write were both high in IDLE
//   dbg_state_o - current FSM state (0=CLEAR 1=IDLE 2=WAIT 3=DONE)
//
// Handshake: a request is accepted on a rising edge where ready=1 and
// exactly one of read/write is high. The initiator holds the request
// until it sees ready=1 at an edge; requests made while ready=0 are
// dropped. Once accepted, addr and data_in are latched, so the inputs
// may change freely. ack pulses for exactly one cycle, and ready returns
// on the cycle after ack.
module mem_responder #(
    parameter int ADDR_WIDTH  = 5,
    parameter int DATA_WIDTH  = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  ready,
    output logic                  ack,
    output logic                  err,
    output logic [1:0]            dbg_state_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    // The sweep counter has one spare bit, so the compare against
    // DEPTH-1 never has to rely on a wrap-around.
    localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [3:0]          WS_LOAD   = 4'(WAIT_STATES);
    localparam bit                  NO_WAIT   = (WAIT_STATES == 0);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic [3:0]              wait_q, wait_d;
    logic                    op_wr_q, op_wr_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic                    err_q, err_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    rd_en;
    logic [ADDR_WIDTH-1:0]   rd_addr;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        wait_d    = wait_q;
        op_wr_d   = op_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        dout_d    = dout_q;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        mem_wdata = wdata_q;
        rd_en     = 1'b0;
        rd_addr   = addr_q;

        case (state_q)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = count_q[ADDR_WIDTH-1:0];
                mem_wdata = '0;
                count_d   = count_q + 1'b1;
                if (count_q == LAST_ADDR) begin
                    state_d = S_IDLE;
                end
            end

            S_IDLE: begin
                if (read && write) begin
                    // Illegal request: report it and stay available.
                    err_d = 1'b1;
                end else if (read || write) begin
                    op_wr_d = write;
                    addr_d  = addr;
                    wdata_d = data_in;
                    if (NO_WAIT) begin
                        // Without wait states the access completes on the
                        // accepting edge, so use the live inputs directly.
                        state_d = S_DONE;
                        if (write) begin
                            mem_we    = 1'b1;
                            mem_waddr = addr;
                            mem_wdata = data_in;
                        end else begin
                            rd_en   = 1'b1;
                            rd_addr = addr;
                        end
                    end else begin
                        wait_d  = WS_LOAD;
                        state_d = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                if (wait_q == 4'd1) begin
                    state_d = S_DONE;
                    if (op_wr_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rd_en = 1'b1;
                    end
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_CLEAR;
                count_d = '0;
            end
        endcase

        if (rd_en) begin
            dout_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CLEAR;
            count_q <= '0;
            wait_q  <= '0;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            dout_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wait_q  <= wait_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
        end
    end

    // The array itself has no reset; the CLEAR sweep zeroes it. Reset
    // blocks writes, so an access aborted by reset never lands.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign data_out    = dout_q;
    assign ready       = (state_q == S_IDLE);
    assign ack         = (state_q == S_DONE);
    assign err         = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder. Instance 0 runs with WAIT_STATES=0 and
// instance 1 with WAIT_STATES=3; both share one clock. Directed vectors
// carry hand-computed expectations.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_v  [2];
    logic       rd_v   [2];
    logic       wr_v   [2];
    logic [4:0] addr_v [2];
    logic [7:0] din_v  [2];

    logic [7:0] dout0, dout1;
    logic       rdy0, rdy1, ack0, ack1, err0, err1;
    logic [1:0] st0, st1;

    mem_responder #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst_v[0]), .read(rd_v[0]), .write(wr_v[0]),
        .addr(addr_v[0]), .data_in(din_v[0]), .data_out(dout0),
        .ready(rdy0), .ack(ack0), .err(err0), .dbg_state_o(st0)
    );

    mem_responder #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst_v[1]), .read(rd_v[1]), .write(wr_v[1]),
        .addr(addr_v[1]), .data_in(din_v[1]), .data_out(dout1),
        .ready(rdy1), .ack(ack1), .err(err1), .dbg_state_o(st1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q [$];

    typedef struct {
        bit         is_wr;
        logic [4:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    function automatic logic f_rdy(int d);
        return (d == 0) ? rdy0 : rdy1;
    endfunction
    function automatic logic f_ack(int d);
        return (d == 0) ? ack0 : ack1;
    endfunction
    function automatic logic f_err(int d);
        return (d == 0) ? err0 : err1;
    endfunction
    function automatic logic [7:0] f_dout(int d);
        return (d == 0) ? dout0 : dout1;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic timeout(string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Pulses reset for two edges, then counts edges until ready rises.
    // With poke set, a write to addr 2 is driven mid-sweep and released
    // before the sweep ends; it must be dropped.
    task automatic do_reset(int d, bit poke, output int cycles);
        bit saw_ack = 1'b0;
        @(negedge clk);
        rst_v[d] = 1'b1;
        rd_v[d]  = 1'b0;
        wr_v[d]  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check($sformatf("rst_ready%0d", d), f_rdy(d), 0);
        check($sformatf("rst_ack%0d", d),   f_ack(d), 0);
        check($sformatf("rst_err%0d", d),   f_err(d), 0);
        check($sformatf("rst_dout%0d", d),  f_dout(d), 0);
        rst_v[d] = 1'b0;
        cycles = 0;
        while (cycles < 100) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (f_ack(d)) saw_ack = 1'b1;
            if (poke && cycles == 3) begin
                wr_v[d]   = 1'b1;
                addr_v[d] = 5'd2;
                din_v[d]  = 8'h11;
            end
            if (poke && cycles == 20) wr_v[d] = 1'b0;
            if (f_rdy(d)) break;
        end
        wr_v[d] = 1'b0;
        if (cycles >= 100) timeout("clear_sweep");
        check($sformatf("clear_no_ack%0d", d), saw_ack, 0);
    endtask

    // One access; starts and ends on a falling edge. lat counts edges from
    // the accepting edge (inclusive) to the edge after which ack is seen.
    task automatic access(int d, bit is_wr, logic [4:0] a, logic [7:0] wd,
                          output logic [7:0] rdata, output int lat,
                          output int acc_cyc, output int rdy_low);
        int guard = 0;
        while (!f_rdy(d) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) timeout("wait_ready");
        rd_v[d]   = !is_wr;
        wr_v[d]   = is_wr;
        addr_v[d] = a;
        din_v[d]  = wd;
        @(posedge clk);
        #1 acc_cyc = cyc;
        @(negedge clk);
        // Scramble inputs after accept; the latched copies must be used.
        rd_v[d]   = 1'b0;
        wr_v[d]   = 1'b0;
        addr_v[d] = ~a;
        din_v[d]  = ~wd;
        lat = 1;
        rdy_low = 0;
        while (!f_ack(d) && lat < 50) begin
            if (!f_rdy(d)) rdy_low++;
            @(negedge clk);
            lat++;
        end
        if (lat >= 50) timeout("wait_ack");
        if (!f_rdy(d)) rdy_low++;
        check("ack_no_err", f_err(d), 0);
        rdata = f_dout(d);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t       vecs [$];
        logic [7:0] rdata;
        logic [7:0] last_rd;
        logic [7:0] e;
        int         lat, acc, prev_acc, low, c;

        for (int d = 0; d < 2; d++) begin
            rst_v[d] = 1'b1; rd_v[d] = 1'b0; wr_v[d] = 1'b0;
            addr_v[d] = '0;  din_v[d] = '0;
        end

        // Reset clear: ready rises 32 cycles after reset falls.
        do_reset(0, 1'b0, c);
        check("clear_cycles0", c, 32);
        do_reset(1, 1'b0, c);
        check("clear_cycles1", c, 32);

        // Every word reads zero after the sweep, with one-cycle latency.
        for (int i = 0; i < 32; i++) begin
            access(0, 1'b0, 5'(i), 8'h00, rdata, lat, acc, low);
            check($sformatf("clr_rd[%0d]", i), rdata, 8'h00);
            check($sformatf("clr_lat[%0d]", i), lat, 1);
        end
        last_rd = 8'h00;

        // Data = address, then a few distinct patterns, back to back.
        for (int i = 0; i < 32; i++) vecs.push_back('{1'b1, 5'(i), 8'(i), 8'h00});
        for (int i = 0; i < 32; i++) vecs.push_back('{1'b0, 5'(i), 8'h00, 8'(i)});
        vecs.push_back('{1'b1, 5'd10, 8'h3C, 8'h00});
        vecs.push_back('{1'b1, 5'd21, 8'hC3, 8'h00});
        vecs.push_back('{1'b0, 5'd10, 8'h00, 8'h3C});
        vecs.push_back('{1'b0, 5'd21, 8'h00, 8'hC3});
        vecs.push_back('{1'b0, 5'd0,  8'h00, 8'h00});
        vecs.push_back('{1'b0, 5'd31, 8'h00, 8'h1F});
        vecs.push_back('{1'b1, 5'd10, 8'd10, 8'h00});
        vecs.push_back('{1'b1, 5'd21, 8'd21, 8'h00});

        prev_acc = -1;
        foreach (vecs[k]) begin
            if (!vecs[k].is_wr) exp_q.push_back(vecs[k].exp);
            access(0, vecs[k].is_wr, vecs[k].a, vecs[k].d, rdata, lat, acc, low);
            check($sformatf("vec_lat[%0d]", k), lat, 1);
            if (prev_acc >= 0) check($sformatf("vec_period[%0d]", k), acc - prev_acc, 2);
            prev_acc = acc;
            if (vecs[k].is_wr) begin
                check($sformatf("wr_keeps_dout[%0d]", k), rdata, last_rd);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("vec_rd[%0d]", k), rdata, e);
                last_rd = e;
            end
        end

        // Illegal request: err pulses once, no ack, ready stays high.
        @(negedge clk);
        check("ill_ready_before", rdy0, 1);
        rd_v[0] = 1'b1; wr_v[0] = 1'b1; addr_v[0] = 5'd3; din_v[0] = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        rd_v[0] = 1'b0; wr_v[0] = 1'b0;
        check("ill_err", err0, 1);
        check("ill_ack", ack0, 0);
        check("ill_ready", rdy0, 1);
        @(negedge clk);
        check("ill_err_pulse", err0, 0);
        check("ill_ack_after", ack0, 0);
        access(0, 1'b0, 5'd3, 8'h00, rdata, lat, acc, low);
        check("ill_addr3_kept", rdata, 8'h03);

        // Wait states = 3: latency 4 edges, ready low 4 cycles, period 5.
        access(1, 1'b1, 5'h1F, 8'hA5, rdata, lat, prev_acc, low);
        check("ws_wr_lat", lat, 4);
        check("ws_wr_rdy_low", low, 4);
        access(1, 1'b0, 5'h1F, 8'h00, rdata, lat, acc, low);
        check("ws_rd_lat", lat, 4);
        check("ws_rd_rdy_low", low, 4);
        check("ws_rd_data", rdata, 8'hA5);
        check("ws_period", acc - prev_acc, 5);

        // Reset during WAIT aborts the write to addr 7.
        while (!rdy1) @(negedge clk);
        wr_v[1] = 1'b1; addr_v[1] = 5'd7; din_v[1] = 8'h5A;
        @(posedge clk);
        @(negedge clk);
        wr_v[1] = 1'b0;
        check("mid_in_wait", st1, 2);
        check("mid_no_ack", ack1, 0);
        do_reset(1, 1'b0, c);
        check("mid_clear_cycles", c, 32);
        access(1, 1'b0, 5'd7, 8'h00, rdata, lat, acc, low);
        check("mid_addr7_zero", rdata, 8'h00);
        access(1, 1'b0, 5'h1F, 8'h00, rdata, lat, acc, low);
        check("mid_addr1f_zero", rdata, 8'h00);

        // Write held during CLEAR and released before ready is dropped.
        do_reset(0, 1'b1, c);
        check("poke_clear_cycles", c, 32);
        access(0, 1'b0, 5'd2, 8'h00, rdata, lat, acc, low);
        check("poke_addr2_zero", rdata, 8'h00);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
